// File: rtl/counter_pkg.sv
// ------------------------------------------------------------------
// counter_pkg: shared count width, bounds and step encoding. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;
  localparam logic [COUNT_W-1:0] COUNT_MIN = 4'h0;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ------------------------------------------------------------------
// btn_debounce: 2-flop sync, stable-level debouncer, press pulse. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic [1:0]       valid_q;
  logic             armed_q;
  logic             level_q;
  logic             level_d;
  logic             prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter tracks the run of samples disagreeing with the accepted level.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      valid_q <= 2'b00;
      armed_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      valid_q <= {valid_q[0], 1'b1};
      // A button held through reset must be seen released before it can press.
      if (valid_q[1] && !sync2_q) begin
        armed_q <= 1'b1;
      end
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press = level_q & ~prev_q & armed_q;

endmodule

`default_nettype wire

// File: rtl/up_down_count_core.sv
// ------------------------------------------------------------------
// up_down_count_core: debounced manual/auto 4-bit up/down counter.
// COUNT_WRAP_EN defined: wrap at bounds, otherwise saturate. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module up_down_count_core
  import counter_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int DB_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               clr,
  input  logic               auto_en,
  input  logic               dir,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               at_max,
  output logic               at_min
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

`ifdef COUNT_WRAP_EN
  localparam logic [COUNT_W-1:0] UP_AT_MAX   = COUNT_MIN;
  localparam logic [COUNT_W-1:0] DOWN_AT_MIN = COUNT_MAX;
`else
  localparam logic [COUNT_W-1:0] UP_AT_MAX   = COUNT_MAX;
  localparam logic [COUNT_W-1:0] DOWN_AT_MIN = COUNT_MIN;
`endif

  logic               press_up;
  logic               press_down;
  logic [PRE_W-1:0]   presc_q;
  logic [PRE_W-1:0]   presc_d;
  logic               tick_q;
  logic               tick_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  step_e              step;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_up),
    .press   (press_up)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_down),
    .press   (press_down)
  );

  always_comb begin
    presc_d = (presc_q == PRE_LAST) ? '0 : presc_q + PRE_W'(1);
    count_d = count_q;
    step    = STEP_NONE;
    // Any manual pulse, even a cancelling pair, blocks the auto step.
    if (press_up || press_down) begin
      if (press_up && !press_down) begin
        step = STEP_UP;
      end else if (press_down && !press_up) begin
        step = STEP_DOWN;
      end
    end else if (tick_q && auto_en) begin
      step = dir ? STEP_UP : STEP_DOWN;
    end
    unique case (step)
      STEP_UP:   count_d = (count_q == COUNT_MAX) ? UP_AT_MAX : count_q + COUNT_W'(1);
      STEP_DOWN: count_d = (count_q == COUNT_MIN) ? DOWN_AT_MIN : count_q - COUNT_W'(1);
      default:   count_d = count_q;
    endcase
    if (clr) begin
      count_d = COUNT_MIN;
      presc_d = '0;
    end
    tick_d = (presc_d == PRE_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      count_q <= COUNT_MIN;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign tick   = tick_q;
  assign at_max = (count_q == COUNT_MAX);
  assign at_min = (count_q == COUNT_MIN);

endmodule

`default_nettype wire
